// File: rtl/hand_accumulator_if.sv
// hand_accumulator_if: card request and hand report bundle
// between game control and the score accumulator.
interface hand_accumulator_if #(
  parameter int HSEL_W  = 1,
  parameter int SCORE_W = 5
);
  logic               Clear;
  logic               Sum;
  logic [HSEL_W-1:0]  Hand_Sel;
  logic [3:0]         Card_Value;
  logic               Busy;
  logic               Done;
  logic               Error;
  logic [SCORE_W-1:0] Hand_Total;
  logic               Soft;
  logic               Bust;
  logic               Blackjack;
  logic [3:0]         Card_Count;
  logic [HSEL_W-1:0]  Hand_Out;

  modport master (
    output Clear, Sum, Hand_Sel, Card_Value,
    input  Busy, Done, Error, Hand_Total,
    input  Soft, Bust, Blackjack,
    input  Card_Count, Hand_Out
  );

  modport slave (
    input  Clear, Sum, Hand_Sel, Card_Value,
    output Busy, Done, Error, Hand_Total,
    output Soft, Bust, Blackjack,
    output Card_Count, Hand_Out
  );
endinterface

// File: rtl/hand_accumulator.sv
// hand_accumulator: multi-hand blackjack score keeper.
// One card per 4 cycles: IDLE -> ADD -> ADJUST -> REPORT.
module hand_accumulator #(
  parameter int NUM_HANDS  = 2,
  parameter int HSEL_W     = 1,
  parameter int SCORE_W    = 5,
  parameter int BUST_LIMIT = 21
) (
  input logic               Clock,
  input logic               Reset,
  hand_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, ADD, ADJUST, REPORT
  } state_t;

  localparam logic [SCORE_W:0] LIMIT =
    (SCORE_W+1)'(BUST_LIMIT);
  localparam logic [SCORE_W:0] ACE_HI =
    (SCORE_W+1)'(11);
  localparam logic [SCORE_W-1:0] TEN =
    SCORE_W'(10);
  localparam logic [SCORE_W-1:0] BJ =
    SCORE_W'(21);

  state_t state_q, state_n;

  logic [SCORE_W-1:0] total_q [NUM_HANDS];
  logic [3:0]         count_q [NUM_HANDS];
  logic [NUM_HANDS-1:0] soft_q;
  logic [NUM_HANDS-1:0] bust_q;

  logic [HSEL_W-1:0]  sel_q;
  logic [3:0]         card_q;
  logic               reject_q;

  logic [SCORE_W-1:0] out_total;
  logic               out_soft;
  logic               out_bust;
  logic               out_bj;
  logic [3:0]         out_count;
  logic [HSEL_W-1:0]  out_hand;

  logic               in_range;
  logic [HSEL_W-1:0]  idx;
  logic [SCORE_W-1:0] cur_total;
  logic               cur_soft;
  logic               cur_bust;
  logic [3:0]         cur_count;
  logic               legal;
  logic               reject_n;
  logic [SCORE_W-1:0] val;
  logic               add_soft;
  logic [SCORE_W-1:0] add_total;
  logic [3:0]         add_count;
  logic               over;
  logic [SCORE_W-1:0] adj_total;
  logic               adj_soft;
  logic               adj_bust;
  logic [SCORE_W-1:0] rep_total;
  logic               rep_soft;
  logic               rep_bust;

  // State register; Clear handled in next-state logic.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state: fixed 4-step walk, Clear aborts.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (bus.Sum) state_n = ADD;
      ADD:     state_n = ADJUST;
      ADJUST:  state_n = REPORT;
      REPORT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.Clear) state_n = IDLE;
  end

  // Card scoring and soft-ace demotion for the selected hand.
  always_comb begin
    in_range  = {{(32-HSEL_W){1'b0}}, sel_q}
                < $unsigned(NUM_HANDS);
    idx       = in_range ? sel_q : '0;
    cur_total = total_q[idx];
    cur_count = count_q[idx];
    cur_soft  = soft_q[idx];
    cur_bust  = bust_q[idx];
    legal     = (card_q >= 4'd1) && (card_q <= 4'd13);
    reject_n  = !legal || !in_range || cur_bust;
    val       = SCORE_W'(card_q);
    add_soft  = cur_soft;
    unique case (1'b1)
      card_q >= 4'd11: val = TEN;
      card_q == 4'd1: begin
        if (({1'b0, cur_total} + ACE_HI) <= LIMIT
            && !cur_soft) begin
          val      = SCORE_W'(11);
          add_soft = 1'b1;
        end else begin
          val = SCORE_W'(1);
        end
      end
      default: val = SCORE_W'(card_q);
    endcase
    add_total = cur_total + val;
    add_count = (cur_count == 4'd15)
                ? cur_count : cur_count + 4'd1;
    over      = {1'b0, cur_total} > LIMIT;
    adj_total = (over && cur_soft)
                ? cur_total - TEN : cur_total;
    adj_soft  = cur_soft && !over;
    adj_bust  = cur_bust || ({1'b0, adj_total} > LIMIT);
    rep_total = reject_q ? cur_total : adj_total;
    rep_soft  = reject_q ? cur_soft  : adj_soft;
    rep_bust  = reject_q ? cur_bust  : adj_bust;
  end

  // Hand storage, request capture and report registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset || bus.Clear) begin
      for (int i = 0; i < NUM_HANDS; i++) begin
        total_q[i] <= '0;
        count_q[i] <= '0;
      end
      soft_q    <= '0;
      bust_q    <= '0;
      sel_q     <= '0;
      card_q    <= '0;
      reject_q  <= 1'b0;
      out_total <= '0;
      out_soft  <= 1'b0;
      out_bust  <= 1'b0;
      out_bj    <= 1'b0;
      out_count <= '0;
      out_hand  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Sum) begin
            sel_q  <= bus.Hand_Sel;
            card_q <= bus.Card_Value;
          end
        end
        ADD: begin
          reject_q <= reject_n;
          if (!reject_n) begin
            total_q[idx] <= add_total;
            count_q[idx] <= add_count;
            soft_q[idx]  <= add_soft;
          end
        end
        ADJUST: begin
          if (!reject_q) begin
            total_q[idx] <= adj_total;
            soft_q[idx]  <= adj_soft;
            bust_q[idx]  <= adj_bust;
          end
          if (in_range) begin
            out_total <= rep_total;
            out_soft  <= rep_soft;
            out_bust  <= rep_bust;
            out_bj    <= (rep_total == BJ)
                         && (cur_count == 4'd2);
            out_count <= cur_count;
            out_hand  <= sel_q;
          end else begin
            out_total <= '0;
            out_soft  <= 1'b0;
            out_bust  <= 1'b0;
            out_bj    <= 1'b0;
            out_count <= '0;
            out_hand  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy       = (state_q != IDLE);
  assign bus.Done       = (state_q == REPORT);
  assign bus.Error      = (state_q == REPORT) && reject_q;
  assign bus.Hand_Total = out_total;
  assign bus.Soft       = out_soft;
  assign bus.Bust       = out_bust;
  assign bus.Blackjack  = out_bj;
  assign bus.Card_Count = out_count;
  assign bus.Hand_Out   = out_hand;

endmodule

// File: tb/tb_hand_accumulator.sv
// tb_hand_accumulator: directed checks of hand scoring,
// handshake timing, Clear and asynchronous Reset.
module tb_hand_accumulator;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  hand_accumulator_if #(.HSEL_W(2), .SCORE_W(5)) b ();

  hand_accumulator #(
    .NUM_HANDS(3), .HSEL_W(2),
    .SCORE_W(5), .BUST_LIMIT(21)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // packed {hand, count, bj, bust, soft, total}
  task automatic rep(input string tag,
                     input int t, input bit s,
                     input bit bu, input bit bj,
                     input int c, input int h);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = {18'd0, b.Hand_Out, b.Card_Count,
           b.Blackjack, b.Bust, b.Soft, b.Hand_Total};
    exp = {18'd0, h[1:0], c[3:0], bj, bu, s, t[4:0]};
    chk(tag, obs, exp);
  endtask

  task automatic send(input string tag,
                      input logic [1:0] sel,
                      input logic [3:0] v,
                      input bit err);
    @(negedge clk);
    b.Sum = 1'b1;
    b.Hand_Sel = sel;
    b.Card_Value = v;
    @(posedge clk); #1;
    b.Sum = 1'b0;
    chk({tag, ".busy"}, 32'(b.Busy), 32'd1);
    @(posedge clk); #1;
    chk({tag, ".done_early"}, 32'(b.Done), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".done"}, 32'(b.Done), 32'd1);
    chk({tag, ".err"}, 32'(b.Error), 32'(err));
    @(posedge clk); #1;
    chk({tag, ".done_late"}, 32'(b.Done), 32'd0);
    chk({tag, ".idle"}, 32'(b.Busy), 32'd0);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    b.Clear = 1'b1;
    @(posedge clk); #1;
    b.Clear = 1'b0;
    rep(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    b.Clear = 1'b0;
    b.Sum = 1'b0;
    b.Hand_Sel = '0;
    b.Card_Value = '0;
    repeat (2) @(posedge clk);
    #1;
    rep("reset_out", 0, 0, 0, 0, 0, 0);
    chk("reset_busy", 32'(b.Busy), 32'd0);
    chk("reset_done", 32'(b.Done), 32'd0);
    chk("reset_err", 32'(b.Error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send("bj1", 2'd0, 4'd1, 0);
    rep("bj1_out", 11, 1, 0, 0, 1, 0);
    send("bj2", 2'd0, 4'd13, 0);
    rep("bj2_out", 21, 1, 0, 1, 2, 0);

    do_clear("clr1");
    send("sd1", 2'd0, 4'd1, 0);
    rep("sd1_out", 11, 1, 0, 0, 1, 0);
    send("sd2", 2'd0, 4'd6, 0);
    rep("sd2_out", 17, 1, 0, 0, 2, 0);
    send("sd3", 2'd0, 4'd9, 0);
    rep("sd3_out", 16, 0, 0, 0, 3, 0);
    send("sd4", 2'd0, 4'd1, 0);
    rep("sd4_out", 17, 0, 0, 0, 4, 0);

    send("bu1", 2'd1, 4'd10, 0);
    rep("bu1_out", 10, 0, 0, 0, 1, 1);
    send("bu2", 2'd1, 4'd8, 0);
    rep("bu2_out", 18, 0, 0, 0, 2, 1);
    send("bu3", 2'd1, 4'd5, 0);
    rep("bu3_out", 23, 0, 1, 0, 3, 1);
    send("bu4", 2'd1, 4'd2, 1);
    rep("bu4_out", 23, 0, 1, 0, 3, 1);

    do_clear("clr2");
    send("in1", 2'd0, 4'd7, 0);
    send("in2", 2'd1, 4'd12, 0);
    rep("in2_out", 10, 0, 0, 0, 1, 1);
    send("in3", 2'd0, 4'd7, 0);
    rep("in3_out", 14, 0, 0, 0, 2, 0);
    send("in4", 2'd1, 4'd1, 0);
    rep("in4_out", 21, 1, 0, 1, 2, 1);
    send("il0", 2'd0, 4'd0, 1);
    rep("il0_out", 14, 0, 0, 0, 2, 0);
    send("il14", 2'd1, 4'd14, 1);
    rep("il14_out", 21, 1, 0, 1, 2, 1);
    send("il15", 2'd0, 4'd15, 1);
    rep("il15_out", 14, 0, 0, 0, 2, 0);
    send("h2", 2'd2, 4'd9, 0);
    rep("h2_out", 9, 0, 0, 0, 1, 2);
    send("oor", 2'd3, 4'd5, 1);
    rep("oor_out", 0, 0, 0, 0, 0, 0);

    // Sum held high through the whole busy window.
    @(negedge clk);
    b.Sum = 1'b1;
    b.Hand_Sel = 2'd0;
    b.Card_Value = 4'd5;
    @(posedge clk); #1;
    b.Card_Value = 4'd3;
    @(posedge clk);
    @(posedge clk); #1;
    chk("hold_done", 32'(b.Done), 32'd1);
    rep("hold_rep", 19, 0, 0, 0, 3, 0);
    @(posedge clk); #1;
    chk("hold_busy", 32'(b.Busy), 32'd0);
    @(negedge clk);
    b.Sum = 1'b0;
    @(posedge clk); #1;
    chk("hold_nobusy", 32'(b.Busy), 32'd0);
    rep("hold_keep", 19, 0, 0, 0, 3, 0);

    // Clear with Sum while in ADJUST.
    @(negedge clk);
    b.Sum = 1'b1;
    b.Card_Value = 4'd2;
    @(posedge clk); #1;
    b.Sum = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b.Clear = 1'b1;
    b.Sum = 1'b1;
    @(posedge clk); #1;
    chk("abort_done", 32'(b.Done), 32'd0);
    chk("abort_busy", 32'(b.Busy), 32'd0);
    rep("abort_out", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    b.Clear = 1'b0;
    b.Sum = 1'b0;
    @(posedge clk); #1;
    chk("abort_nodone", 32'(b.Done), 32'd0);
    send("after_clr", 2'd0, 4'd4, 0);
    rep("after_clr_out", 4, 0, 0, 0, 1, 0);

    // Asynchronous reset during ADD.
    @(negedge clk);
    b.Sum = 1'b1;
    b.Hand_Sel = 2'd1;
    b.Card_Value = 4'd9;
    @(posedge clk); #1;
    b.Sum = 1'b0;
    chk("ar_add", 32'(b.Busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", 32'(b.Busy), 32'd0);
    rep("ar_out", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    send("ar_next", 2'd1, 4'd6, 0);
    rep("ar_next_out", 6, 0, 0, 0, 1, 1);
    send("ar_h0", 2'd0, 4'd3, 0);
    rep("ar_h0_out", 3, 0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
